// File: rtl/dma_dev_port_pkg.sv
// Shared definitions for the DMA device port: FSM state encoding and the
// default bus widths used by dma_dev_port and its buffer.
// No logic; types and constants only.
package dma_dev_port_pkg;

  localparam int DEF_ADD_LEN    = 16;
  localparam int DEF_DATA_LEN   = 16;
  localparam int DEF_FIFO_DEPTH = 5;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_HOLD  = 3'd2,
    ST_XFER  = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERROR = 3'd5
  } state_e;

endpackage

// File: rtl/dma_dev_port_dev_buffer.sv
// Local word buffer: 2^AW x DW, one synchronous write port, two combinational read ports.
// Latency: write visible the cycle after we; reads are zero-cycle.
// Backpressure: none, always accepts. Contents are never reset.
// Ports: clk; we/waddr/wdata write port; raddr_a/rdata_a and raddr_b/rdata_b read ports.
module dev_buffer
  import dma_dev_port_pkg::*;
#(
  parameter int AW = DEF_FIFO_DEPTH,
  parameter int DW = DEF_DATA_LEN
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr_a,
  output logic [DW-1:0] rdata_a,
  input  logic [AW-1:0] raddr_b,
  output logic [DW-1:0] rdata_b
);

  logic [DW-1:0] mem_q [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata_a = mem_q[raddr_a];
  assign rdata_b = mem_q[raddr_b];

endmodule

// File: rtl/dma_dev_port.sv
// Device-side DMA port: takes a local command, requests the DMA controller, then streams words
// between the DMA bus and a local buffer. Latency: cmd -> rqst 1 cycle, rqst -> XFER 2 cycles.
// Backpressure: cmd_ready only in IDLE; DMA paces words with dma_ack; idle-too-long aborts via err.
// Ports: clk/reset; cmd_* local command; buf_* local buffer access; rqst/rd_wr/start_addr/num_words
//        descriptor; dev_ack/dev_in/dma_ack/dev_out/end_flag DMA data path; done/err/xfer_count status.
module dma_dev_port
  import dma_dev_port_pkg::*;
#(
  parameter int ADD_LEN    = DEF_ADD_LEN,
  parameter int DATA_LEN   = DEF_DATA_LEN,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int TIMEOUT    = 1023
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_rd_wr,
  input  logic [ADD_LEN-1:0]    cmd_addr,
  input  logic [FIFO_DEPTH-1:0] cmd_words,
  input  logic                  buf_we,
  input  logic [FIFO_DEPTH-1:0] buf_waddr,
  input  logic [DATA_LEN-1:0]   buf_wdata,
  input  logic [FIFO_DEPTH-1:0] buf_raddr,
  output logic [DATA_LEN-1:0]   buf_rdata,
  output logic                  rqst,
  output logic                  rd_wr,
  output logic [ADD_LEN-1:0]    start_addr,
  output logic [FIFO_DEPTH-1:0] num_words,
  output logic                  dev_ack,
  output logic [DATA_LEN-1:0]   dev_in,
  input  logic                  dma_ack,
  input  logic [DATA_LEN-1:0]   dev_out,
  input  logic                  end_flag,
  output logic                  done,
  output logic                  err,
  output logic [FIFO_DEPTH:0]   xfer_count
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]         TMO_ONE  = 1;
  localparam logic [TW-1:0]         TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [FIFO_DEPTH-1:0] IDX_ONE  = 1;
  localparam logic [FIFO_DEPTH:0]   CNT_ONE  = 1;

  state_e                state_q, state_d;
  logic                  rd_wr_q, rd_wr_d;
  logic [ADD_LEN-1:0]    addr_q, addr_d;
  logic [FIFO_DEPTH-1:0] words_q, words_d;
  logic [FIFO_DEPTH-1:0] idx_q, idx_d;
  logic [FIFO_DEPTH:0]   cnt_q, cnt_d;
  logic [TW-1:0]         tmo_q, tmo_d;

  logic                  bw_we;
  logic [FIFO_DEPTH-1:0] bw_addr;
  logic [DATA_LEN-1:0]   bw_dat;
  logic [DATA_LEN-1:0]   idx_rdat;

  always_comb begin
    state_d = state_q;
    rd_wr_d = rd_wr_q;
    addr_d  = addr_q;
    words_d = words_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    bw_we   = 1'b0;
    bw_addr = buf_waddr;
    bw_dat  = buf_wdata;
    unique case (state_q)
      ST_IDLE: begin
        // Local writes only while no transfer owns the buffer.
        bw_we = buf_we;
        if (cmd_valid) begin
          rd_wr_d = cmd_rd_wr;
          addr_d  = cmd_addr;
          words_d = cmd_words;
          idx_d   = '0;
          cnt_d   = '0;
          tmo_d   = '0;
          state_d = ST_REQ;
        end
      end
      ST_REQ:  state_d = ST_HOLD;
      ST_HOLD: state_d = ST_XFER;
      ST_XFER: begin
        if (dma_ack) begin
          idx_d = idx_q + IDX_ONE;
          if (cnt_q != '1) cnt_d = cnt_q + CNT_ONE;
          tmo_d = '0;
          if (rd_wr_q) begin
            bw_we   = 1'b1;
            bw_addr = idx_q;
            bw_dat  = dev_out;
          end
        end else if (!end_flag) begin
          tmo_d = tmo_q + TMO_ONE;
        end
        // end_flag beats the timeout; tmo_q==TIMEOUT-1 means this is the TIMEOUT-th idle cycle.
        if (end_flag) state_d = ST_DONE;
        else if (!dma_ack && tmo_q == TMO_LAST) state_d = ST_ERROR;
      end
      ST_DONE, ST_ERROR: state_d = ST_IDLE;
      default:           state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      rd_wr_q <= 1'b0;
      addr_q  <= '0;
      words_q <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      rd_wr_q <= rd_wr_d;
      addr_q  <= addr_d;
      words_q <= words_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
    end
  end

  dev_buffer #(
    .AW (FIFO_DEPTH),
    .DW (DATA_LEN)
  ) u_buf (
    .clk     (clk),
    .we      (bw_we),
    .waddr   (bw_addr),
    .wdata   (bw_dat),
    .raddr_a (buf_raddr),
    .rdata_a (buf_rdata),
    .raddr_b (idx_q),
    .rdata_b (idx_rdat)
  );

  logic active;
  assign active     = (state_q != ST_IDLE);
  assign cmd_ready  = (state_q == ST_IDLE);
  assign rqst       = (state_q == ST_REQ);
  assign dev_ack    = (state_q == ST_XFER);
  assign done       = (state_q == ST_DONE);
  assign err        = (state_q == ST_ERROR);
  assign rd_wr      = active & rd_wr_q;
  assign start_addr = active ? addr_q  : '0;
  assign num_words  = active ? words_q : '0;
  assign dev_in     = (dev_ack && !rd_wr_q) ? idx_rdat : '0;
  assign xfer_count = cnt_q;

endmodule

// File: tb/tb_dma_dev_port.sv
module tb_dma_dev_port;

  localparam int TMO = 16;

  logic        clk;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_rd_wr;
  logic [15:0] cmd_addr;
  logic [4:0]  cmd_words;
  logic        buf_we;
  logic [4:0]  buf_waddr;
  logic [15:0] buf_wdata;
  logic [4:0]  buf_raddr;
  logic [15:0] buf_rdata;
  logic        rqst;
  logic        rd_wr;
  logic [15:0] start_addr;
  logic [4:0]  num_words;
  logic        dev_ack;
  logic [15:0] dev_in;
  logic        dma_ack;
  logic [15:0] dev_out;
  logic        end_flag;
  logic        done;
  logic        err;
  logic [5:0]  xfer_count;

  dma_dev_port #(
    .ADD_LEN    (16),
    .DATA_LEN   (16),
    .FIFO_DEPTH (5),
    .TIMEOUT    (TMO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_rd_wr  (cmd_rd_wr),
    .cmd_addr   (cmd_addr),
    .cmd_words  (cmd_words),
    .buf_we     (buf_we),
    .buf_waddr  (buf_waddr),
    .buf_wdata  (buf_wdata),
    .buf_raddr  (buf_raddr),
    .buf_rdata  (buf_rdata),
    .rqst       (rqst),
    .rd_wr      (rd_wr),
    .start_addr (start_addr),
    .num_words  (num_words),
    .dev_ack    (dev_ack),
    .dev_in     (dev_in),
    .dma_ack    (dma_ack),
    .dev_out    (dev_out),
    .end_flag   (end_flag),
    .done       (done),
    .err        (err),
    .xfer_count (xfer_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  // Reference model: the local buffer as a plain array, plus queued read-direction words.
  logic [15:0] mdl_mem [32];
  logic [15:0] stim_q [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int sat(input int n);
    return (n > 63) ? 63 : n;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag, input int exp_cnt);
    chk({tag, "_ready"}, cmd_ready, 1);
    chk({tag, "_rqst"}, rqst, 0);
    chk({tag, "_rd_wr"}, rd_wr, 0);
    chk({tag, "_addr"}, start_addr, 0);
    chk({tag, "_words"}, num_words, 0);
    chk({tag, "_dev_ack"}, dev_ack, 0);
    chk({tag, "_dev_in"}, dev_in, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_count"}, xfer_count, 64'(exp_cnt));
  endtask

  task automatic preload_one(input int i, input logic [15:0] v);
    buf_we = 1'b1; buf_waddr = 5'(i); buf_wdata = v;
    mdl_mem[i] = v;
    step();
    buf_we = 1'b0;
  endtask

  task automatic preload_all();
    for (int i = 0; i < 32; i++) preload_one(i, 16'($urandom));
  endtask

  task automatic dump_check(input string tag);
    for (int i = 0; i < 32; i++) begin
      buf_raddr = 5'(i);
      #1;
      chk({tag, "_buf"}, buf_rdata, mdl_mem[i]);
    end
    step();
  endtask

  // One complete transfer from IDLE through DONE back to IDLE.
  task automatic run_xfer(input bit rw, input logic [15:0] addr, input int nstb,
                          input int gap, input bit rnd_gap, input bit ack_end);
    int g;
    logic [4:0] w;
    w = 5'(nstb);
    chk("idle_ready", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_rd_wr = rw; cmd_addr = addr; cmd_words = w;
    step();
    chk("req_rqst", rqst, 1);
    chk("req_rd_wr", rd_wr, rw);
    chk("req_addr", start_addr, addr);
    chk("req_words", num_words, w);
    chk("req_ready", cmd_ready, 0);
    // These must all be ignored outside IDLE / XFER.
    cmd_rd_wr = ~rw; cmd_addr = ~addr; cmd_words = ~w;
    dma_ack = 1'b1; dev_out = 16'hBAD0;
    step();
    chk("hold_rqst", rqst, 0);
    chk("hold_dev_ack", dev_ack, 0);
    chk("hold_addr", start_addr, addr);
    end_flag = 1'b1;
    step();
    end_flag = 1'b0; dma_ack = 1'b0; cmd_valid = 1'b0;
    chk("xfer_count0", xfer_count, 0);
    for (int s = 0; s < nstb; s++) begin
      g = rnd_gap ? $urandom_range(0, gap) : gap;
      repeat (g) begin
        chk("gap_dev_ack", dev_ack, 1);
        if (!rw) chk("gap_dev_in", dev_in, mdl_mem[s % 32]);
        dma_ack = 1'b0;
        step();
      end
      chk("stb_dev_ack", dev_ack, 1);
      chk("stb_rqst", rqst, 0);
      chk("stb_rd_wr", rd_wr, rw);
      chk("stb_addr", start_addr, addr);
      chk("stb_count", xfer_count, 64'(sat(s)));
      dma_ack = 1'b1;
      if (rw) begin
        dev_out = (stim_q.size() > 0) ? stim_q.pop_front() : 16'($urandom);
        mdl_mem[s % 32] = dev_out;
        chk("stb_dev_in_rd", dev_in, 0);
      end else begin
        chk("stb_dev_in", dev_in, mdl_mem[s % 32]);
      end
      end_flag = ack_end && (s == nstb - 1);
      step();
    end
    dma_ack = 1'b0;
    if (!ack_end) begin
      chk("end_dev_ack", dev_ack, 1);
      end_flag = 1'b1;
      step();
    end
    end_flag = 1'b0;
    chk("done_pulse", done, 1);
    chk("done_err", err, 0);
    chk("done_dev_ack", dev_ack, 0);
    chk("done_count", xfer_count, 64'(sat(nstb)));
    chk("done_addr", start_addr, addr);
    step();
    check_idle_outputs("post", sat(nstb));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    logic [15:0] v;
    reset = 1'b1; cmd_valid = 1'b0; cmd_rd_wr = 1'b0; cmd_addr = '0; cmd_words = '0;
    buf_we = 1'b0; buf_waddr = '0; buf_wdata = '0; buf_raddr = '0;
    dma_ack = 1'b0; dev_out = '0; end_flag = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    step();
    check_idle_outputs("rst", 0);

    preload_all();
    dump_check("preload");

    // Memory-to-device with fixed words.
    stim_q = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    run_xfer(1'b1, 16'h0200, 4, 0, 1'b0, 1'b0);
    dump_check("rd4");

    // Device-to-memory from preloaded words.
    preload_one(0, 16'h00A0);
    preload_one(1, 16'h00A1);
    preload_one(2, 16'h00A2);
    run_xfer(1'b0, 16'h0400, 3, 0, 1'b0, 1'b0);

    // Stalls of 5 cycles, and 15 idle cycles (one short of the timeout).
    run_xfer(1'b1, 16'h1000, 10, 5, 1'b0, 1'b0);
    dump_check("stall_rd");
    run_xfer(1'b0, 16'h1100, 10, 5, 1'b0, 1'b1);
    run_xfer(1'b1, 16'h1200, 3, TMO - 1, 1'b0, 1'b0);
    dump_check("tmo_edge");

    // Timeout with no strobes at all.
    cmd_valid = 1'b1; cmd_rd_wr = 1'b1; cmd_addr = 16'h5000; cmd_words = 5'd7;
    step();
    cmd_valid = 1'b0;
    step();
    step();
    cnt = 0;
    while (dev_ack === 1'b1 && cnt < 40) begin
      cnt++;
      step();
    end
    chk("tmo_cycles", cnt, TMO);
    chk("tmo_err", err, 1);
    chk("tmo_done", done, 0);
    chk("tmo_count", xfer_count, 0);
    step();
    check_idle_outputs("tmo_post", 0);
    dump_check("tmo");

    // Index wrap with ack+end together, then count saturation.
    run_xfer(1'b1, 16'h2000, 33, 0, 1'b0, 1'b1);
    dump_check("wrap33");
    run_xfer(1'b0, 16'h2100, 70, 1, 1'b1, 1'b0);

    // Reset mid-transfer; local write during XFER must not land.
    cmd_valid = 1'b1; cmd_rd_wr = 1'b1; cmd_addr = 16'h3000; cmd_words = 5'd8;
    step();
    cmd_valid = 1'b0;
    step();
    step();
    for (int k = 0; k < 5; k++) begin
      dma_ack = 1'b1;
      dev_out = 16'($urandom);
      mdl_mem[k] = dev_out;
      step();
    end
    dma_ack = 1'b0;
    v = ~mdl_mem[20];
    buf_we = 1'b1; buf_waddr = 5'd20; buf_wdata = v;
    step();
    buf_we = 1'b0;
    chk("rst_mid_xfer", dev_ack, 1);
    chk("rst_mid_count", xfer_count, 5);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_idle_outputs("rst_mid", 0);
    repeat (3) begin
      step();
      chk("rst_after_done", done, 0);
      chk("rst_after_err", err, 0);
    end
    dump_check("rst_mid");

    // Randomized transfers.
    for (int it = 0; it < 8; it++) begin
      bit rw;
      rw = 1'($urandom);
      if (!rw) preload_all();
      run_xfer(rw, 16'($urandom), $urandom_range(1, 40), 6, 1'b1, 1'($urandom));
      dump_check("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
